// File: rtl/mem_stream_reader.sv
// mem_stream_reader
// Reads a burst of consecutive words from a synchronous-read memory port and
// presents them as a valid/ready stream. A two-entry output buffer absorbs
// the one-cycle memory latency, so reads are throttled only when the buffer
// and the read in flight would otherwise exceed two words.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; base_addr/length captured on acceptance
// READ  | issuing memory reads while words remain and buffer has room
// DRAIN | all reads issued; waiting for the tagged last word to leave
// DONE  | one-cycle completion pulse, then back to IDLE

module mem_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_SIZE   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest meaningful burst; longer requests would only revisit addresses.
    localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;

    state_t                  state;
    logic [ADDR_WIDTH:0]     rem;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH:0]     len_eff;

    logic                    pend;
    logic                    pend_last;

    logic [1:0]              occ;
    logic [DATA_WIDTH-1:0]   slot0_data;
    logic [DATA_WIDTH-1:0]   slot1_data;
    logic                    slot0_last;
    logic                    slot1_last;

    logic                    push;
    logic                    pop;
    logic                    last_read;
    logic [2:0]              occ_proj;

    assign len_eff = (length > LEN_MAX) ? LEN_MAX : length;

    assign m_valid = (occ != 2'd0);
    assign m_data  = slot0_data;
    // slot0_last may be stale once the buffer empties, so qualify it.
    assign m_last  = m_valid && slot0_last;

    assign pop  = m_valid && m_ready;
    assign push = pend;

    // Words that will be held or in flight after this cycle if no read is
    // issued now; a new read is allowed only if that stays below two.
    assign occ_proj = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};

    assign mem_read_en = !rst && (state == READ) && (rem != LEN_ZERO) &&
                         (occ_proj < 3'd2);
    assign last_read   = mem_read_en && (rem == LEN_ONE);

    assign mem_read_address = rd_addr;

    // Burst sequencing: capture request, count reads down, registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rem     <= '0;
            rd_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rd_addr <= base_addr;
                        rem     <= len_eff;
                        busy    <= 1'b1;
                        if (len_eff == LEN_ZERO) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                READ: begin
                    if (mem_read_en) begin
                        rd_addr <= rd_addr + 1'b1;
                        rem     <= rem - 1'b1;
                        if (last_read) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && slot0_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Track the read in flight and whether it carries the last-word tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend      <= mem_read_en;
            pend_last <= last_read;
        end
    end

    // Two-entry output buffer; slot0 is always the head of the stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= 2'd0;
            slot0_data <= '0;
            slot1_data <= '0;
            slot0_last <= 1'b0;
            slot1_last <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        slot0_data <= mem_data_out;
                        slot0_last <= pend_last;
                    end else begin
                        slot1_data <= mem_data_out;
                        slot1_last <= pend_last;
                    end
                    occ <= occ + 1'b1;
                end
                2'b01: begin
                    slot0_data <= slot1_data;
                    slot0_last <= slot1_last;
                    occ        <= occ - 1'b1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        slot0_data <= mem_data_out;
                        slot0_last <= pend_last;
                    end else begin
                        slot0_data <= slot1_data;
                        slot0_last <= slot1_last;
                        slot1_data <= mem_data_out;
                        slot1_last <= pend_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width of memory and output stream.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, memory address width.
REQ-003 SHALL have parameter MEM_SIZE, default 32, number of memory words; MEM_SIZE = 2^ADDR_WIDTH.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-008 base_addr  input  ADDR_WIDTH  first word address; captured when start is accepted.
REQ-009 length  input  ADDR_WIDTH+1  word count, 0..MEM_SIZE; captured when start is accepted.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at burst completion.
REQ-012 mem_read_en  output  1  read strobe to the memory read port.
REQ-013 mem_read_address  output  ADDR_WIDTH  memory read address.
REQ-014 mem_data_out  input  DATA_WIDTH  memory read data, valid one cycle after mem_read_en.
REQ-015 m_data  output  DATA_WIDTH  stream data.
REQ-016 m_valid  output  1  stream data valid.
REQ-017 m_ready  input  1  downstream accept.
REQ-018 m_last  output  1  high with the final word of the burst.

Function
REQ-019 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-020 IDLE -> READ when start=1 and length!=0; IDLE -> DONE when start=1 and length=0; otherwise stay.
REQ-021 READ -> DRAIN in the cycle after the last of length reads is issued.
REQ-022 DRAIN -> DONE in the cycle after the final word (m_last) handshakes (m_valid && m_ready).
REQ-023 DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-024 start asserted outside IDLE SHALL be ignored; base_addr/length changes after acceptance SHALL have no effect.
REQ-025 Read i (i=0..length-1) SHALL use address (base_addr + i) mod 2^ADDR_WIDTH; wrap from MEM_SIZE-1 to 0 without error.
REQ-026 mem_read_en SHALL be high only in READ, only while reads remain, and only when occ + pend - pop < 2, where occ = output buffer occupancy, pend = mem_read_en of the previous cycle, pop = m_valid && m_ready this cycle.
REQ-027 mem_data_out SHALL be captured into a 2-entry output FIFO exactly in the cycle after each mem_read_en; the FIFO SHALL never overflow.
REQ-028 m_valid SHALL equal FIFO non-empty; m_data SHALL be the FIFO head; the head SHALL be popped only on m_valid && m_ready.
REQ-029 m_data/m_valid/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-030 Latency: start accepted in cycle n -> mem_read_en=1 with base address in n+1 -> m_valid=1 with mem[base_addr] in n+3.
REQ-031 With m_ready held high, throughput SHALL be one word per cycle; length L completes with done in cycle n+L+3.
REQ-032 m_last SHALL be set on word length-1 only, and its tag travels with that word through the FIFO.
REQ-033 Words SHALL be emitted in address order, each exactly once, with no loss under arbitrary m_ready patterns.

Reset
REQ-034 With rst=1 at a clock edge: state=IDLE, FIFO emptied, read counters cleared, busy=0, done=0, mem_read_en=0, mem_read_address=0, m_valid=0, m_last=0, m_data=0.
REQ-035 Reset mid-burst SHALL abort the burst; in-flight read data returning the following cycle SHALL be discarded; no done pulse.

Verification
REQ-036 mem preloaded mem[k]=k+16'h100; start, base=3, length=4, m_ready=1 -> m_data 0x103,0x104,0x105,0x106 in cycles n+3..n+6, m_last on 0x106, done in n+7.
REQ-037 base=30, length=4 -> read addresses 30,31,0,1; data mem[30],mem[31],mem[0],mem[1].
REQ-038 length=6, m_ready toggled 1,0,0,1,0,1... -> all 6 words in order, none duplicated, m_data stable during stalls, mem_read_en never raises occ above 2.
REQ-039 length=0 -> no mem_read_en, no m_valid, done pulses in n+1, busy high only in that cycle.
REQ-040 start re-pulsed mid-burst with different base/length -> ignored; original burst completes unchanged.
REQ-041 rst asserted in READ with 2 words buffered -> next cycle m_valid=0, busy=0, mem_read_en=0; subsequent fresh burst correct.
